lcd_timing_gen: RTL and testbench

- Drives the 480x272 parallel RGB LCD panel.
- Derives a pixel tick from `clock` and generates horizontal and vertical timing, so it is the source of the `x`/`y` coordinates that the game/graphics logic consumes.
- Samples the colour returned for the current `x`/`y` and presents it on the panel pins, aligned with HSYNC, VSYNC and DE.

---
 rtl/lcd_timing_pkg.sv | 54 +++++
 rtl/lcd_axis_counter.sv | 86 ++++++++
 rtl/lcd_timing_gen.sv | 192 +++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg
// Shared types and constants for the 480x272 parallel RGB LCD timing
// generator: the per-axis state encoding, the default panel timing and the
// colour-bar pattern used by the optional test-pattern generator
// (TEST_PATTERN_EN).
// ---------------------------------------------------------------------------
package lcd_timing_pkg;

  // Segments of one timing axis, visited in declaration order.
  typedef enum logic [1:0] {
    ACT,
    FRONT,
    SYNC,
    BACK
  } axis_state_t;

  // Default timing: 27 MHz system clock, 9 MHz pixel clock.
  localparam int DEF_CLK_DIV  = 3;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FRONT  = 8;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BACK   = 43;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FRONT  = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 12;

  // Colour bars: each entry is {red, green, blue} on/off flags; a set flag
  // means full scale for that component.
  localparam int         BAR_WIDTH   = 60;
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// ---------------------------------------------------------------------------
// lcd_axis_counter
// One timing axis (horizontal or vertical): a four-segment FSM
// ACT -> FRONT -> SYNC -> BACK -> ACT, a segment counter that restarts on
// every segment entry, and a position counter 0..TOTAL-1.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high
//   advance  in   move the axis one step this clock
//   state    out  current segment
//   pos      out  position within the axis period
//   wrap     out  this advance leaves BACK (position returns to 0)
// ---------------------------------------------------------------------------
module lcd_axis_counter #(
  parameter int ACTIVE = 480,
  parameter int FRONT  = 8,
  parameter int SYNC   = 4,
  parameter int BACK   = 43,
  parameter int POS_W  = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        advance,
  output lcd_timing_pkg::axis_state_t state,
  output logic [POS_W-1:0]            pos,
  output logic                        wrap
);

  // Parameter names FRONT/SYNC/BACK shadow the enum literals, so the
  // states are referenced through the package scope here.
  lcd_timing_pkg::axis_state_t state_next;
  lcd_timing_pkg::axis_state_t succ;
  logic [POS_W-1:0]            seg_cnt;
  logic [POS_W-1:0]            seg_last;
  logic                        seg_done;

  // NOTE: every variable written here gets a value before the case so no
  // path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    seg_last = POS_W'(ACTIVE - 1);
    succ     = lcd_timing_pkg::FRONT;
    unique case (state)
      lcd_timing_pkg::ACT: begin
        seg_last = POS_W'(ACTIVE - 1);
        succ     = lcd_timing_pkg::FRONT;
      end
      lcd_timing_pkg::FRONT: begin
        seg_last = POS_W'(FRONT - 1);
        succ     = lcd_timing_pkg::SYNC;
      end
      lcd_timing_pkg::SYNC: begin
        seg_last = POS_W'(SYNC - 1);
        succ     = lcd_timing_pkg::BACK;
      end
      lcd_timing_pkg::BACK: begin
        seg_last = POS_W'(BACK - 1);
        succ     = lcd_timing_pkg::ACT;
      end
    endcase
    seg_done   = (seg_cnt == seg_last);
    wrap       = advance && seg_done && (state == lcd_timing_pkg::BACK);
    state_next = (advance && seg_done) ? succ : state;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= lcd_timing_pkg::ACT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_cnt <= '0;
      pos     <= '0;
    end else if (advance) begin
      seg_cnt <= seg_done ? '0 : seg_cnt + 1'b1;
      pos     <= wrap ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
// Timing generator for a 480x272 parallel RGB LCD. Divides clock into a
// pixel tick, runs horizontal and vertical timing, publishes the current
// x/y to the graphics logic and drives the panel with the returned colour,
// one tick later and aligned with DE/HSYNC/VSYNC.
//
// Optional feature: define TEST_PATTERN_EN to add an 8-bar colour
// generator selected by test_mode; without it test_mode is ignored.
//
// Ports:
//   clock, reset           system clock; synchronous active-high reset
//   x, y, display_on       current pixel (0 outside active region)
//   frame_start            one-clock pulse as timing returns to (0,0)
//   red_in/green_in/blue_in colour for current x/y (combinational return)
//   test_mode              select test pattern (TEST_PATTERN_EN only)
//   lcd_pclk               pixel clock to the panel
//   lcd_de                 data enable
//   lcd_hsync, lcd_vsync   syncs, active-low
//   lcd_r, lcd_g, lcd_b    panel colour
// ---------------------------------------------------------------------------
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic       clock,
  input  logic       reset,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       display_on,
  output logic       frame_start,
  input  logic [4:0] red_in,
  input  logic [5:0] green_in,
  input  logic [4:0] blue_in,
  input  logic       test_mode,
  output logic       lcd_pclk,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             tick;

  axis_state_t h_state;
  axis_state_t v_state;
  logic [9:0]  h_pos;
  logic [8:0]  v_pos;
  logic        h_wrap;
  logic        v_wrap;

  // Sync conditions of the pixel currently on x/y, delayed with it.
  logic        hsync_cond;
  logic        vsync_cond;

  logic [4:0]  pix_r;
  logic [5:0]  pix_g;
  logic [4:0]  pix_b;

  // -------------------------------------------------------------------------
  // Pixel clock divider. lcd_pclk is low for the first half of each pixel
  // period so its rising edge lands mid-pixel, after the data change.
  // -------------------------------------------------------------------------
  assign tick     = (div_cnt == DIV_LAST);
  assign div_next = tick ? '0 : div_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      lcd_pclk <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      lcd_pclk <= (div_next >= DIV_HALF);
    end
  end

  // -------------------------------------------------------------------------
  // Axis timing: V steps once per line, when H leaves its back porch.
  // -------------------------------------------------------------------------
  lcd_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POS_W  (10)
  ) u_h_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (tick),
    .state   (h_state),
    .pos     (h_pos),
    .wrap    (h_wrap)
  );

  lcd_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POS_W  (9)
  ) u_v_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (h_wrap),
    .state   (v_state),
    .pos     (v_pos),
    .wrap    (v_wrap)
  );

  // -------------------------------------------------------------------------
  // Colour source.
  // -------------------------------------------------------------------------
`ifdef TEST_PATTERN_EN
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;

  always_comb begin
    bar_idx = 3'(x / 9'(BAR_WIDTH));
    bar_rgb = bar_color(bar_idx);
    pix_r   = red_in;
    pix_g   = green_in;
    pix_b   = blue_in;
    if (test_mode) begin
      pix_r = {5{bar_rgb[2]}};
      pix_g = {6{bar_rgb[1]}};
      pix_b = {5{bar_rgb[0]}};
    end
  end
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign pix_r            = red_in;
  assign pix_g            = green_in;
  assign pix_b            = blue_in;
`endif

  // -------------------------------------------------------------------------
  // Coordinate stage and panel stage. On a tick the coordinate stage shows
  // the pixel the counters point at, while the panel stage takes the colour
  // returned for the pixel shown since the previous tick.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      display_on  <= 1'b0;
      hsync_cond  <= 1'b0;
      vsync_cond  <= 1'b0;
      frame_start <= 1'b0;
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
    end else begin
      frame_start <= v_wrap;
      if (tick) begin
        x          <= (h_state == ACT) ? 9'(h_pos) : '0;
        y          <= (v_state == ACT) ? v_pos : '0;
        display_on <= (h_state == ACT) && (v_state == ACT);
        hsync_cond <= (h_state == SYNC);
        vsync_cond <= (v_state == SYNC);
        lcd_de     <= display_on;
        lcd_hsync  <= !hsync_cond;
        lcd_vsync  <= !vsync_cond;
        lcd_r      <= display_on ? pix_r : '0;
        lcd_g      <= display_on ? pix_g : '0;
        lcd_b      <= display_on ? pix_b : '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_gen
// Self-checking bench for lcd_timing_gen. A default-parameter instance is
// checked against a table of hand-computed points on the first two lines;
// a small-parameter instance covers whole-frame timing and mid-frame reset
// within a short run. With TEST_PATTERN_EN defined the colour bars are
// checked as well.
// ---------------------------------------------------------------------------
module tb_lcd_timing_gen;

  logic       clock;
  logic       reset;
  logic       test_mode;
  logic [8:0] x, y;
  logic       display_on, frame_start;
  logic [4:0] red_in, blue_in;
  logic [5:0] green_in;
  logic       lcd_pclk, lcd_de, lcd_hsync, lcd_vsync;
  logic [4:0] lcd_r, lcd_b;
  logic [5:0] lcd_g;

  logic       s_reset;
  logic [8:0] s_x, s_y;
  logic       s_display_on, s_frame_start;
  logic [4:0] s_red_in, s_blue_in;
  logic [5:0] s_green_in;
  logic       s_lcd_pclk, s_lcd_de, s_lcd_hsync, s_lcd_vsync;
  logic [4:0] s_lcd_r, s_lcd_b;
  logic [5:0] s_lcd_g;

  int n_compared = 0;
  int n_mism     = 0;
  int edges      = 0;

  // Graphics-side colour return: a pure function of the published x/y.
  assign red_in     = x[4:0];
  assign green_in   = {y[2:0], x[2:0]};
  assign blue_in    = y[4:0];
  assign s_red_in   = s_x[4:0];
  assign s_green_in = {s_y[2:0], s_x[2:0]};
  assign s_blue_in  = s_y[4:0];

  lcd_timing_gen u_dut (
    .clock       (clock),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .display_on  (display_on),
    .frame_start (frame_start),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .test_mode   (test_mode),
    .lcd_pclk    (lcd_pclk),
    .lcd_de      (lcd_de),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_r       (lcd_r),
    .lcd_g       (lcd_g),
    .lcd_b       (lcd_b)
  );

  // Small panel: H 6/2/2/3 (13 px), V 4/1/2/1 (8 lines), 2 clocks per pixel.
  lcd_timing_gen #(
    .CLK_DIV  (2),
    .H_ACTIVE (6),
    .H_FRONT  (2),
    .H_SYNC   (2),
    .H_BACK   (3),
    .V_ACTIVE (4),
    .V_FRONT  (1),
    .V_SYNC   (2),
    .V_BACK   (1)
  ) u_small (
    .clock       (clock),
    .reset       (s_reset),
    .x           (s_x),
    .y           (s_y),
    .display_on  (s_display_on),
    .frame_start (s_frame_start),
    .red_in      (s_red_in),
    .green_in    (s_green_in),
    .blue_in     (s_blue_in),
    .test_mode   (1'b0),
    .lcd_pclk    (s_lcd_pclk),
    .lcd_de      (s_lcd_de),
    .lcd_hsync   (s_lcd_hsync),
    .lcd_vsync   (s_lcd_vsync),
    .lcd_r       (s_lcd_r),
    .lcd_g       (s_lcd_g),
    .lcd_b       (s_lcd_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mism++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic main_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    edges = 0;
  endtask

  // Advance the main instance to just after rising edge e (counted from
  // reset release) and stop on the following falling edge.
  task automatic step_to(input int e);
    while (edges < e) begin
      @(posedge clock);
      edges++;
    end
    @(negedge clock);
  endtask

  // Tick n happens on rising edge 3*n after release. Pixel p is on x/y
  // after tick p+1 and on the panel after tick p+2.
  typedef struct {
    int         n;
    logic [8:0] x;
    logic [8:0] y;
    logic       don;
    logic       de;
    logic       hs;
    logic       vs;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  typedef struct {
    int         n;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } tp_t;

  localparam int NTP = 7;
  tp_t tps [NTP];

  logic [63:0] rst_exp;

  initial begin
    //           n    x    y    don de hs vs r   g  b
    vecs[0]  = '{1,   0,   0,   1,  0, 1, 1, 0,  0, 0};
    vecs[1]  = '{2,   1,   0,   1,  1, 1, 1, 0,  0, 0};
    vecs[2]  = '{3,   2,   0,   1,  1, 1, 1, 1,  1, 0};
    vecs[3]  = '{33,  32,  0,   1,  1, 1, 1, 31, 7, 0};
    vecs[4]  = '{34,  33,  0,   1,  1, 1, 1, 0,  0, 0};
    vecs[5]  = '{480, 479, 0,   1,  1, 1, 1, 30, 6, 0};
    vecs[6]  = '{481, 0,   0,   0,  1, 1, 1, 31, 7, 0};
    vecs[7]  = '{482, 0,   0,   0,  0, 1, 1, 0,  0, 0};
    vecs[8]  = '{489, 0,   0,   0,  0, 1, 1, 0,  0, 0};
    vecs[9]  = '{490, 0,   0,   0,  0, 0, 1, 0,  0, 0};
    vecs[10] = '{493, 0,   0,   0,  0, 0, 1, 0,  0, 0};
    vecs[11] = '{494, 0,   0,   0,  0, 1, 1, 0,  0, 0};
    vecs[12] = '{536, 0,   1,   1,  0, 1, 1, 0,  0, 0};
    vecs[13] = '{537, 1,   1,   1,  1, 1, 1, 0,  8, 1};

    //          n    r   g   b      panel pixel x = n-2
    tps[0] = '{2,   31, 63, 31};  // 0   white
    tps[1] = '{61,  31, 63, 31};  // 59  white
    tps[2] = '{62,  31, 63, 0};   // 60  yellow
    tps[3] = '{122, 0,  63, 31};  // 120 cyan
    tps[4] = '{421, 0,  0,  31};  // 419 blue
    tps[5] = '{422, 0,  0,  0};   // 420 black
    tps[6] = '{481, 0,  0,  0};   // 479 black

    // {x, y, display_on, frame_start, pclk, de, hsync, vsync, r, g, b}
    rst_exp = 64'({9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 6'd0, 5'd0});

    reset     = 1'b1;
    s_reset   = 1'b1;
    test_mode = 1'b0;

    // ---- Reset state and pixel clock shape --------------------------------
    main_reset();
    check("rst_state", 64'({x, y, display_on, frame_start, lcd_pclk, lcd_de,
                            lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b}), rst_exp);
    step_to(1);
    check("pclk_e1", 64'(lcd_pclk), 64'd1);
    step_to(2);
    check("pclk_e2", 64'(lcd_pclk), 64'd1);
    check("don_before_tick", 64'(display_on), 64'd0);
    step_to(3);
    check("pclk_e3", 64'(lcd_pclk), 64'd0);
    check("don_first_tick", 64'(display_on), 64'd1);
    step_to(4);
    check("pclk_e4", 64'(lcd_pclk), 64'd1);

    // ---- Table: first two lines --------------------------------------------
    main_reset();
    for (int i = 0; i < NV; i++) begin
      step_to(3 * vecs[i].n);
      check($sformatf("v%0d_x", i),   64'(x),          64'(vecs[i].x));
      check($sformatf("v%0d_y", i),   64'(y),          64'(vecs[i].y));
      check($sformatf("v%0d_don", i), 64'(display_on), 64'(vecs[i].don));
      check($sformatf("v%0d_de", i),  64'(lcd_de),     64'(vecs[i].de));
      check($sformatf("v%0d_hs", i),  64'(lcd_hsync),  64'(vecs[i].hs));
      check($sformatf("v%0d_vs", i),  64'(lcd_vsync),  64'(vecs[i].vs));
      check($sformatf("v%0d_r", i),   64'(lcd_r),      64'(vecs[i].r));
      check($sformatf("v%0d_g", i),   64'(lcd_g),      64'(vecs[i].g));
      check($sformatf("v%0d_b", i),   64'(lcd_b),      64'(vecs[i].b));
      check($sformatf("v%0d_fs", i),  64'(frame_start), 64'd0);
    end

`ifdef TEST_PATTERN_EN
    // ---- Colour bars -------------------------------------------------------
    test_mode = 1'b1;
    main_reset();
    for (int i = 0; i < NTP; i++) begin
      step_to(3 * tps[i].n);
      check($sformatf("tp%0d_r", i), 64'(lcd_r), 64'(tps[i].r));
      check($sformatf("tp%0d_g", i), 64'(lcd_g), 64'(tps[i].g));
      check($sformatf("tp%0d_b", i), 64'(lcd_b), 64'(tps[i].b));
    end
    test_mode = 1'b0;
`endif

    // ---- Small panel: two frame_start pulses, one frame of sync/DE --------
    // Frame = 13 * 8 * 2 = 208 clocks; first pulse right after edge 208.
    // Per frame: VSYNC low 2 lines * 13 px * 2 clocks = 52 clocks,
    // DE high 4 lines * 6 px * 2 clocks = 48 clocks.
    begin
      int first   = -1;
      int second  = -1;
      int fs_cnt  = 0;
      int vs_low  = 0;
      int de_high = 0;
      @(negedge clock);
      s_reset = 1'b1;
      repeat (2) @(negedge clock);
      s_reset = 1'b0;
      for (int e = 1; e <= 700 && second < 0; e++) begin
        @(posedge clock);
        @(negedge clock);
        if (e == 1) check("s_pclk_e1", 64'(s_lcd_pclk), 64'd1);
        if (e == 2) check("s_pclk_e2", 64'(s_lcd_pclk), 64'd0);
        if (s_frame_start && first >= 0) begin
          second = e;
        end else begin
          if (s_frame_start) first = e;
          if (first >= 0) begin
            fs_cnt  += int'(s_frame_start);
            vs_low  += int'(!s_lcd_vsync);
            de_high += int'(s_lcd_de);
          end
        end
      end
      check("s_first_fs_edge", 64'(first), 64'd208);
      check("s_fs_spacing", 64'(second - first), 64'd208);
      check("s_fs_width", 64'(fs_cnt), 64'd1);
      check("s_vsync_low_clks", 64'(vs_low), 64'd52);
      check("s_de_high_clks", 64'(de_high), 64'd48);
    end

    // ---- Small panel: reset mid-frame at x=3, y=2 -------------------------
    begin
      bit found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
        @(negedge clock);
        if (s_x == 9'd3 && s_y == 9'd2 && s_display_on) found = 1'b1;
      end
      check("s_reach_x3_y2", 64'(found), 64'd1);
      s_reset = 1'b1;
      @(negedge clock);
      check("s_mid_reset_state", 64'({s_x, s_y, s_display_on, s_frame_start, s_lcd_pclk,
                                      s_lcd_de, s_lcd_hsync, s_lcd_vsync,
                                      s_lcd_r, s_lcd_g, s_lcd_b}), rst_exp);
      s_reset = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check("s_restart_xy", 64'({s_x, s_y}), 64'd0);
      check("s_restart_don", 64'(s_display_on), 64'd1);
      check("s_restart_de", 64'(s_lcd_de), 64'd0);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check("s_restart_x1", 64'(s_x), 64'd1);
      check("s_restart_de1", 64'(s_lcd_de), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mism);
    $finish;
  end

endmodule
